// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side program counter sequencer.
package pc_seq_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

    localparam addr_t PC_STEP            = ADDR_W'(4);
    localparam addr_t DEFAULT_RESET_ADDR = ADDR_W'(32'h0000_0000);
    localparam addr_t DEFAULT_EXC_VECTOR = ADDR_W'(32'h0000_0180);
    localparam addr_t ALIGN_MASK         = ADDR_W'(32'hFFFF_FFFC);

    // Redirect held while a fetch is still outstanding
    typedef struct packed {
        logic  valid;
        addr_t target;
    } pend_redirect_t;

    // Targets are word aligned by clearing the byte-offset bits
    function automatic addr_t align_addr(input addr_t a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority select of the highest redirect source and its word-aligned target.
// Exception source present only when PC_SEQ_EXC_EN is defined.
module pc_redirect_sel
    import pc_seq_pkg::*;
`ifdef PC_SEQ_EXC_EN
#(
    parameter addr_t EXC_VECTOR = DEFAULT_EXC_VECTOR
)
`endif
(
`ifdef PC_SEQ_EXC_EN
    input  logic        exception,
    output logic        exc_sel_c,
`endif
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        redirect_c,
    output logic [31:0] target_c
);

    always_comb begin
        redirect_c = 1'b0;
        target_c   = '0;
`ifdef PC_SEQ_EXC_EN
        exc_sel_c  = 1'b0;
        if (exception) begin
            redirect_c = 1'b1;
            exc_sel_c  = 1'b1;
            target_c   = align_addr(EXC_VECTOR);
        end else
`endif
        if (jump) begin
            redirect_c = 1'b1;
            target_c   = align_addr(jump_target);
        end else if (branch_taken) begin
            redirect_c = 1'b1;
            target_c   = align_addr(branch_target);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner sequencing one outstanding instruction fetch at a time.
// Optional exception redirect and EPC capture enabled by PC_SEQ_EXC_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter addr_t RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter addr_t EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
`ifdef PC_SEQ_EXC_EN
    input  logic        Exception,
    output logic [31:0] EPC,
`endif
    output logic        FetchReq,
    output logic [31:0] FetchAddr,
    input  logic        FetchReady,
    output logic [31:0] PCResult,
    output logic        InstrValid,
    output logic [31:0] InstrPC
);

    seq_state_t     state_q, state_d;
    addr_t          pc_q, pc_d;
    pend_redirect_t pend_q, pend_d;
    logic           fetch_req_q;
    logic           instr_valid_q, instr_valid_d;
    addr_t          instr_pc_q, instr_pc_d;

    logic           redir_c;
    addr_t          redir_target_c;
    logic           accept_c;

`ifdef PC_SEQ_EXC_EN
    logic           redir_exc_c;
    logic           pend_exc_q, pend_exc_d;
    logic           epc_load_c;
    addr_t          epc_q;
`else
    logic           unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    pc_redirect_sel
`ifdef PC_SEQ_EXC_EN
    #(
        .EXC_VECTOR    (EXC_VECTOR)
    )
`endif
    u_redirect_sel (
`ifdef PC_SEQ_EXC_EN
        .exception     (Exception),
        .exc_sel_c     (redir_exc_c),
`endif
        .jump          (Jump),
        .jump_target   (JumpTarget),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .redirect_c    (redir_c),
        .target_c      (redir_target_c)
    );

    // FetchReady only counts while a request is actually on the bus
    assign accept_c = fetch_req_q & FetchReady;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        instr_valid_d = 1'b0;
        instr_pc_d    = instr_pc_q;
`ifdef PC_SEQ_EXC_EN
        pend_exc_d    = pend_exc_q;
        epc_load_c    = 1'b0;
`endif
        case (state_q)
            BOOT, HOLD: begin
                if (redir_c) begin
                    pc_d = redir_target_c;
`ifdef PC_SEQ_EXC_EN
                    epc_load_c = redir_exc_c;
`endif
                end
                state_d = Stall ? HOLD : FETCH;
            end
            FETCH: begin
                if (accept_c) begin
                    // A redirect squashes the just-accepted fetch
                    if (redir_c) begin
                        pc_d = redir_target_c;
`ifdef PC_SEQ_EXC_EN
                        epc_load_c = redir_exc_c;
`endif
                    end else if (pend_q.valid) begin
                        pc_d = pend_q.target;
`ifdef PC_SEQ_EXC_EN
                        epc_load_c = pend_exc_q;
`endif
                    end else begin
                        pc_d          = pc_q + PC_STEP;
                        instr_valid_d = 1'b1;
                        instr_pc_d    = pc_q;
                    end
                    pend_d  = '0;
`ifdef PC_SEQ_EXC_EN
                    pend_exc_d = 1'b0;
`endif
                    state_d = Stall ? HOLD : FETCH;
                end else if (redir_c) begin
                    pend_d.valid  = 1'b1;
                    pend_d.target = redir_target_c;
`ifdef PC_SEQ_EXC_EN
                    pend_exc_d    = redir_exc_c;
`endif
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_ADDR;
            pend_q        <= '0;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            fetch_req_q   <= (state_d == FETCH);
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

`ifdef PC_SEQ_EXC_EN
    // EPC captures the PC being left when an exception redirect lands
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_exc_q <= 1'b0;
            epc_q      <= '0;
        end else begin
            pend_exc_q <= pend_exc_d;
            if (epc_load_c) begin
                epc_q <= pc_q;
            end
        end
    end

    assign EPC = epc_q;
`endif

    assign FetchReq   = fetch_req_q;
    assign FetchAddr  = pc_q;
    assign PCResult   = pc_q;
    assign InstrValid = instr_valid_q;
    assign InstrPC    = instr_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a cycle-level reference model.
// Exception paths exercised when PC_SEQ_EXC_EN is defined.
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Exception;
    logic        FetchReq;
    logic [31:0] FetchAddr;
    logic        FetchReady;
    logic [31:0] PCResult;
    logic        InstrValid;
    logic [31:0] InstrPC;
`ifdef PC_SEQ_EXC_EN
    logic [31:0] EPC;
`endif

    int n_vec;
    int n_err;

    // Reference model: phase 0 = booting, 1 = request on the bus, 2 = held off
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_pend;
    logic        m_pend_exc;
    logic        m_ivalid;
    logic [31:0] m_ipc;
    logic [31:0] m_epc;

    pc_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
`ifdef PC_SEQ_EXC_EN
        .Exception    (Exception),
        .EPC          (EPC),
`endif
        .FetchReq     (FetchReq),
        .FetchAddr    (FetchAddr),
        .FetchReady   (FetchReady),
        .PCResult     (PCResult),
        .InstrValid   (InstrValid),
        .InstrPC      (InstrPC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic jmp, input logic [31:0] jt,
                         input logic br, input logic [31:0] bt, input logic rdy, input logic exc);
        Reset        = rst;
        Stall        = stl;
        Jump         = jmp;
        JumpTarget   = jt;
        BranchTaken  = br;
        BranchTarget = bt;
        FetchReady   = rdy;
        Exception    = exc;
    endtask

    // Highest-priority redirect this cycle, aligned down to a multiple of 4
    task automatic pick(output logic v, output logic [31:0] t, output logic e);
        v = 1'b1;
        e = 1'b0;
        t = 32'h0;
        if (Exception) begin
            e = 1'b1;
            t = 32'h180;
        end else if (Jump) begin
            t = (JumpTarget / 4) * 4;
        end else if (BranchTaken) begin
            t = (BranchTarget / 4) * 4;
        end else begin
            v = 1'b0;
        end
    endtask

    task automatic move_pc(input logic [31:0] t, input logic exc);
        if (exc) m_epc = m_pc;
        m_pc = t;
    endtask

    task automatic model_step();
        logic        rv;
        logic        re;
        logic [31:0] rt;
        if (Reset) begin
            m_phase  = 0;
            m_pc     = 32'h0;
            m_pend_v = 1'b0;
            m_ivalid = 1'b0;
            m_ipc    = 32'h0;
            m_epc    = 32'h0;
            return;
        end
        pick(rv, rt, re);
        m_ivalid = 1'b0;
        if (m_phase != 1) begin
            if (rv) move_pc(rt, re);
            m_phase = Stall ? 2 : 1;
        end else if (FetchReady) begin
            if (rv) move_pc(rt, re);
            else if (m_pend_v) move_pc(m_pend, m_pend_exc);
            else begin
                m_ipc    = m_pc;
                m_pc     = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                m_ivalid = 1'b1;
            end
            m_pend_v = 1'b0;
            m_phase  = Stall ? 2 : 1;
        end else if (rv) begin
            m_pend_v   = 1'b1;
            m_pend     = rt;
            m_pend_exc = re;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        #1;
        check("FetchReq", 32'(FetchReq), 32'(m_phase == 1));
        check("FetchAddr", FetchAddr, m_pc);
        check("PCResult", PCResult, m_pc);
        check("InstrValid", 32'(InstrValid), 32'(m_ivalid));
        if (m_ivalid) check("InstrPC", InstrPC, m_ipc);
`ifdef PC_SEQ_EXC_EN
        check("EPC", EPC, m_epc);
`endif
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFFC;
        else if ($urandom_range(0, 1) == 0) r = r & 32'h0000_03FF;
        return r;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        m_phase = 0;
        m_pc = 0; m_pend_v = 0; m_pend = 0; m_pend_exc = 0;
        m_ivalid = 0; m_ipc = 0; m_epc = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // Reset, then back-to-back accepts
        step();
        step();
        check("boot_req", 32'(FetchReq), 32'h0);
        check("reset_ivalid", 32'(InstrValid), 32'h0);
        check("reset_ipc", InstrPC, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        check("first_req", 32'(FetchReq), 32'h1);
        check("first_addr", FetchAddr, 32'h0);
        step();
        check("addr_4", FetchAddr, 32'h4);
        check("ipc_0", InstrPC, 32'h0);
        step();
        check("addr_8", FetchAddr, 32'h8);
        check("ipc_4", InstrPC, 32'h4);
        step();
        step();
        check("addr_10", FetchAddr, 32'h10);

        // Branch held while fetch outstanding, applied with squash
        drive(0, 0, 0, 0, 1, 32'h40, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("held_addr", FetchAddr, 32'h10);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        check("pend_pc", PCResult, 32'h40);
        check("pend_squash", 32'(InstrValid), 32'h0);
        step();
        check("after_pend", FetchAddr, 32'h44);

        // Jump beats branch in the same accept cycle
        drive(0, 0, 1, 32'h200, 1, 32'h300, 1, 0);
        step();
        check("jump_prio", PCResult, 32'h200);
        check("jump_squash", 32'(InstrValid), 32'h0);

        // Stall during an outstanding fetch
        drive(0, 0, 1, 32'h20, 0, 0, 1, 0);
        step();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("stall_req_held", 32'(FetchReq), 32'h1);
        check("stall_addr_held", FetchAddr, 32'h20);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        step();
        check("stall_pc", PCResult, 32'h24);
        check("stall_req_drop", 32'(FetchReq), 32'h0);
        step();
        check("hold_ignores_ready", 32'(FetchReq), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("resume_addr", FetchAddr, 32'h24);
        check("resume_req", 32'(FetchReq), 32'h1);

        // Wrap at the top of the address space and target alignment
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        check("wrap", FetchAddr, 32'h0);
        drive(0, 0, 1, 32'h103, 0, 0, 1, 0);
        step();
        check("align", FetchAddr, 32'h100);

`ifdef PC_SEQ_EXC_EN
        // Exception beats a same-cycle jump and records the faulting PC
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 21; i++) step();
        check("pre_exc_pc", PCResult, 32'h50);
        drive(0, 0, 1, 32'h200, 0, 0, 1, 1);
        step();
        check("exc_pc", PCResult, 32'h180);
        check("exc_epc", EPC, 32'h50);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), rand_target(),
                  ($urandom_range(0, 7) == 0), rand_target(),
                  ($urandom_range(0, 1) == 0),
`ifdef PC_SEQ_EXC_EN
                  ($urandom_range(0, 15) == 0)
`else
                  1'b0
`endif
                  );
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
